// File: rtl/up_down_counter_mod.sv
// Loadable up/down counter with a programmable modulus (0..MAX_VAL).
// SAT_MODE=0 wraps at the bound, SAT_MODE=1 saturates there.
// tc is a combinational terminal-count flag. ovf/udf are one-cycle
// registered pulses for a step taken from the terminal count.
module up_down_counter_mod #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter bit SAT_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic             updown,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             udf
);

  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_VAL);
  localparam bit               FULL    = (MAX_VAL == (2**WIDTH)-1);

  logic [WIDTH-1:0] load_val;
  logic             at_max;
  logic             at_zero;

  // A full-range modulus cannot be exceeded by any load value, so the
  // clamp comparator only exists for a reduced modulus.
  if (FULL) begin : g_no_clamp
    assign load_val = data;
  end else begin : g_clamp
    assign load_val = (data > MAX_V) ? MAX_V : data;
  end

  assign at_max  = (count == MAX_V);
  assign at_zero = (count == '0);

  // Terminal count follows updown without waiting for a clock edge.
  always_comb begin
    tc = updown ? at_max : at_zero;
  end

  // Count register and boundary pulses; priority is rst > load > en.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else if (load) begin
      count <= load_val;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else if (en) begin
      ovf <= 1'b0;
      udf <= 1'b0;
      if (updown) begin
        if (at_max) begin
          ovf <= 1'b1;
          if (!SAT_MODE) count <= '0;
        end else begin
          count <= count + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          udf <= 1'b1;
          if (!SAT_MODE) count <= MAX_V;
        end else begin
          count <= count - WIDTH'(1);
        end
      end
    end else begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Bench for up_down_counter_mod. Three instances share one stimulus
// stream: modulus 10 wrapping, modulus 10 saturating, modulus 16
// wrapping. A modular-arithmetic model is checked on every falling edge,
// and directed literal checks pin the model at the boundaries.
module tb_up_down_counter_mod;

  localparam int W = 4;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic         en = 1'b0;
  logic         updown = 1'b1;
  logic [W-1:0] data = '0;

  logic [W-1:0] count [N];
  logic         tc    [N];
  logic         ovf   [N];
  logic         udf   [N];

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Per-instance modulus (MAX_VAL) and saturation mode.
  int m_max [N] = '{9, 9, 15};
  bit m_sat [N] = '{1'b0, 1'b1, 1'b0};

  // Model state.
  int m_count [N] = '{0, 0, 0};
  bit m_ovf   [N] = '{1'b0, 1'b0, 1'b0};
  bit m_udf   [N] = '{1'b0, 1'b0, 1'b0};

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  up_down_counter_mod #(.WIDTH(W), .MAX_VAL(9), .SAT_MODE(1'b0)) u_wrap10 (
    .clk(clk), .rst(rst), .load(load), .en(en), .updown(updown), .data(data),
    .count(count[0]), .tc(tc[0]), .ovf(ovf[0]), .udf(udf[0]));

  up_down_counter_mod #(.WIDTH(W), .MAX_VAL(9), .SAT_MODE(1'b1)) u_sat10 (
    .clk(clk), .rst(rst), .load(load), .en(en), .updown(updown), .data(data),
    .count(count[1]), .tc(tc[1]), .ovf(ovf[1]), .udf(udf[1]));

  up_down_counter_mod #(.WIDTH(W), .MAX_VAL(15), .SAT_MODE(1'b0)) u_wrap16 (
    .clk(clk), .rst(rst), .load(load), .en(en), .updown(updown), .data(data),
    .count(count[2]), .tc(tc[2]), .ovf(ovf[2]), .udf(udf[2]));

  // ---------------- scoreboard helper ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Counting is arithmetic modulo MAX_VAL+1; saturation simply refuses to
  // leave the bound. Flags report that the step started at the bound.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      int modn;
      int d;
      modn = m_max[i] + 1;
      if (rst) begin
        m_count[i] = 0; m_ovf[i] = 1'b0; m_udf[i] = 1'b0;
      end else if (load) begin
        d = int'(data);
        m_count[i] = (d > m_max[i]) ? m_max[i] : d;
        m_ovf[i] = 1'b0; m_udf[i] = 1'b0;
      end else if (en && updown) begin
        m_ovf[i] = (m_count[i] == m_max[i]);
        m_udf[i] = 1'b0;
        if (!(m_sat[i] && m_ovf[i])) m_count[i] = (m_count[i] + 1) % modn;
      end else if (en) begin
        m_udf[i] = (m_count[i] == 0);
        m_ovf[i] = 1'b0;
        if (!(m_sat[i] && m_udf[i])) m_count[i] = (m_count[i] + modn - 1) % modn;
      end else begin
        m_ovf[i] = 1'b0; m_udf[i] = 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        int exp_tc;
        exp_tc = updown ? int'(m_count[i] == m_max[i]) : int'(m_count[i] == 0);
        chk($sformatf("model_count[%0d]", i), int'(count[i]), m_count[i]);
        chk($sformatf("model_tc[%0d]", i),    int'(tc[i]),    exp_tc);
        chk($sformatf("model_ovf[%0d]", i),   int'(ovf[i]),   int'(m_ovf[i]));
        chk($sformatf("model_udf[%0d]", i),   int'(udf[i]),   int'(m_udf[i]));
      end
    end
  end

  // ---------------- driver ----------------
  // Inputs change 1 time unit after a falling edge, so both the model and
  // the compare process always see stable values.
  task automatic step(input bit r, input bit l, input bit e, input bit u,
                      input logic [W-1:0] d);
    #1;
    rst = r; load = l; en = e; updown = u; data = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    @(negedge clk);

    // Reset dominates load.
    step(1, 1, 1, 1, 5);
    chk_en = 1'b1;
    step(1, 1, 1, 1, 5);
    chk("rst_count", int'(count[0]), 0);
    chk("rst_ovf",   int'(ovf[0]),   0);
    chk("rst_udf",   int'(udf[0]),   0);

    // Wrap up through 9.
    step(0, 1, 0, 1, 8);
    chk("load8", int'(count[0]), 8);
    step(0, 0, 1, 1, 0);
    chk("up_to9",   int'(count[0]), 9);
    chk("tc_at9",   int'(tc[0]),    1);
    chk("ovf_at9",  int'(ovf[0]),   0);
    step(0, 0, 1, 1, 0);
    chk("wrap_to0", int'(count[0]), 0);
    chk("ovf_at0",  int'(ovf[0]),   1);
    step(0, 0, 1, 1, 0);
    chk("up_to1",   int'(count[0]), 1);
    chk("ovf_at1",  int'(ovf[0]),   0);

    // Mid-count reset at 6.
    repeat (5) step(0, 0, 1, 1, 0);
    chk("reach6", int'(count[0]), 6);
    step(1, 0, 1, 1, 0);
    chk("mid_rst", int'(count[0]), 0);

    // Wrap down through 0.
    step(0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0);
    chk("down_to0",  int'(count[0]), 0);
    chk("tc_down0",  int'(tc[0]),    1);
    step(0, 0, 1, 0, 0);
    chk("wrap_to9",  int'(count[0]), 9);
    chk("udf_at9",   int'(udf[0]),   1);
    step(0, 0, 1, 0, 0);
    chk("down_to8",  int'(count[0]), 8);
    chk("udf_at8",   int'(udf[0]),   0);

    // Saturating instance held at 9.
    step(0, 1, 0, 1, 9);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 1, 0);
      chk("sat_hold9", int'(count[1]), 9);
      chk("sat_ovf",   int'(ovf[1]),   1);
    end
    step(0, 0, 1, 0, 0);
    chk("sat_down8",   int'(count[1]), 8);
    chk("sat_ovf_clr", int'(ovf[1]),   0);

    // Load clamp, load under reset, hold with en=0.
    step(0, 1, 1, 1, 13);
    chk("clamp9",   int'(count[0]), 9);
    chk("clamp16",  int'(count[2]), 13);
    step(1, 1, 0, 1, 13);
    chk("rst_over_load", int'(count[0]), 0);
    step(0, 1, 1, 0, 13);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 1, 0);
      chk("hold9", int'(count[0]), 9);
    end

    // Full-range instance rolls over 15 -> 0.
    step(0, 1, 0, 1, 15);
    step(0, 0, 1, 1, 0);
    chk("full_wrap0", int'(count[2]), 0);
    chk("full_ovf",   int'(ovf[2]),   1);

    // From 10, alternate direction every 10 edges, then random traffic.
    step(0, 1, 0, 1, 10);
    for (int k = 0; k < 60; k++) step(0, 0, 1, ((k / 10) % 2) == 0, 0);
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) != 0,
           ((k / 10) % 2) == 0 ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0),
           W'($urandom_range(0, 15)));
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
